sm4_sbox_arbiter: RTL and testbench

Round-robin controller that shares one 32-bit masked SM4 S-box layer (four byte S-boxes, start/finish handshake) between two requesters: the round-function datapath (port 0) and the key-expansion datapath (port 1). It accepts one masked word pair (x share, m share) at a time and sequences the S-box layer's start pulse. It waits for finish, watchdogs the S-box latency, and returns the substituted shares to the requester that issued them. Shares are never combined inside this block.

---
 rtl/sm4_sbox_arbiter.sv | 149 ++++++++++++++
 tb/tb_sm4_sbox_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_sbox_arbiter.sv
// sm4_sbox_arbiter: round-robin sharing of one 32-bit masked SM4 S-box layer between two
// requesters (port 0 = round function, port 1 = key expansion). One operation at a time.
// The data and mask shares travel in separate registers and are never combined here.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   reqN_valid/ready, reqN_x/m     operand pair handshake per requester (ready is combinational)
//   rspN_valid/ready, rsp_x/m      result handshake per requester, shared result bus
//   sb_start, sb_x/m               one-cycle start pulse and held operands to the S-box layer
//   sb_finish, sb_x_out/m_out      S-box completion (level or pulse) and results
//   busy, err                      not-idle indication, sticky watchdog timeout
module sm4_sbox_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_m,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_m,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_x,
  output logic [31:0] rsp_m,
  output logic        sb_start,
  output logic [31:0] sb_x,
  output logic [31:0] sb_m,
  input  logic        sb_finish,
  input  logic [31:0] sb_x_out,
  input  logic [31:0] sb_m_out,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StErr} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [31:0]       op_x_q, op_x_d, op_m_q, op_m_d;
  logic [31:0]       res_x_q, res_x_d, res_m_q, res_m_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              gnt0, gnt1, rsp_take;

  // Tie goes to the requester not served last.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = (state_q == StIdle) & gnt0;
  assign req1_ready = (state_q == StIdle) & gnt1;

  assign rsp_take = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_x_d       = op_x_q;
    op_m_d       = op_m_q;
    res_x_d      = res_x_q;
    res_m_d      = res_m_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0 | gnt1) begin
          op_x_d       = gnt1 ? req1_x : req0_x;
          op_m_d       = gnt1 ? req1_m : req0_m;
          owner_d      = gnt1;
          last_grant_d = gnt1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Only a finish sampled here counts, so a level left over from the previous
        // operation (seen during ISSUE) cannot complete this one early.
        if (sb_finish) begin
          res_x_d = sb_x_out;
          res_m_d = sb_m_out;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          state_d = StErr;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_take) begin
          op_x_d  = '0;
          op_m_d  = '0;
          res_x_d = '0;
          res_m_d = '0;
          state_d = StIdle;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_x_q       <= '0;
      op_m_q       <= '0;
      res_x_q      <= '0;
      res_m_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_x_q       <= op_x_d;
      op_m_q       <= op_m_d;
      res_x_q      <= res_x_d;
      res_m_q      <= res_m_d;
      cnt_q        <= cnt_d;
    end
  end

  // Remaining outputs are decodes of registered state only.
  assign sb_start   = (state_q == StIssue);
  assign sb_x       = op_x_q;
  assign sb_m       = op_m_q;
  assign rsp0_valid = (state_q == StResp) & ~owner_q;
  assign rsp1_valid = (state_q == StResp) & owner_q;
  assign rsp_x      = res_x_q;
  assign rsp_m      = res_m_q;
  assign busy       = (state_q != StIdle);
  assign err        = (state_q == StErr);

endmodule

// File: tb/tb_sm4_sbox_arbiter.sv
// Directed bench for sm4_sbox_arbiter: behavioural S-box layer with programmable latency,
// scoreboard of expected results pushed at accept and popped at response handshake.
module tb_sm4_sbox_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x = '0, req0_m = '0, req1_x = '0, req1_m = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_x, rsp_m;
  logic        sb_start;
  logic [31:0] sb_x, sb_m;
  logic        sb_finish = 1'b0;
  logic [31:0] sb_x_out, sb_m_out;
  logic        busy, err;

  int total = 0;
  int bad   = 0;

  sm4_sbox_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_x    (req0_x),
    .req0_m    (req0_m),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_x    (req1_x),
    .req1_m    (req1_m),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp_x     (rsp_x),
    .rsp_m     (rsp_m),
    .sb_start  (sb_start),
    .sb_x      (sb_x),
    .sb_m      (sb_m),
    .sb_finish (sb_finish),
    .sb_x_out  (sb_x_out),
    .sb_m_out  (sb_m_out),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Stand-in for the S-box layer: distinct bijections per share.
  function automatic logic [31:0] fx(input logic [31:0] v);
    return {v[23:0], v[31:24]} ^ 32'h3C3C_C3C3;
  endfunction
  function automatic logic [31:0] fm(input logic [31:0] v);
    return ~{v[7:0], v[31:8]} ^ 32'h0F1E_2D3C;
  endfunction

  assign sb_x_out = fx(sb_x);
  assign sb_m_out = fm(sb_m);

  // Latency model: finish is high during the cycle lat cycles after the start cycle.
  // lat == 0 means never finish; stale_hold forces finish high continuously.
  int lat = 3;
  bit stale_hold = 1'b0;
  int cd = 0;
  always @(negedge clk) begin
    sb_finish = stale_hold;
    if (rst) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) sb_finish = 1'b1;
      end
      if (sb_start && lat > 0) cd = lat;
    end
  end

  typedef struct {
    bit          port;
    logic [31:0] ix;
    logic [31:0] im;
    logic [31:0] ex;
    logic [31:0] em;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    assert (got === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic push(input bit port, input logic [31:0] x, input logic [31:0] m);
    exp_t e;
    e.port = port;
    e.ix   = x;
    e.im   = m;
    e.ex   = fx(x);
    e.em   = fm(m);
    sb_q.push_back(e);
  endtask

  // One clock: sample handshakes late in the cycle, then advance to just after the edge.
  task automatic step();
    exp_t e;
    #1;
    if (req0_valid && req0_ready) push(1'b0, req0_x, req0_m);
    if (req1_valid && req1_ready) push(1'b1, req1_x, req1_m);
    chk("rsp_exclusive", 64'(rsp0_valid & rsp1_valid), 64'd0);
    if (sb_start && sb_q.size() > 0) begin
      e = sb_q[$];
      chk("sb_operands", {sb_x, sb_m}, {e.ix, e.im});
    end
    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
      total++;
      assert (sb_q.size() > 0)
      else begin
        bad++;
        $error("FAIL rsp_unexpected observed=%0d expected=>0 queued", sb_q.size());
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rsp_port", 64'(rsp1_valid), 64'(e.port));
        chk("rsp_data", {rsp_x, rsp_m}, {e.ex, e.em});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input bit port, input int maxc);
    int n = 0;
    while (!(port ? rsp1_valid : rsp0_valid) && n < maxc) begin
      step();
      n++;
    end
    chk("wait_rsp", 64'(port ? rsp1_valid : rsp0_valid), 64'd1);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    while ((sb_q.size() > 0 || busy) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_queue", 64'(sb_q.size()), 64'd0);
    chk("drain_idle", 64'(busy), 64'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    stale_hold = 1'b0;
    #1;
    sb_q.delete();
    chk("rst_ctrl", 64'({busy, err, sb_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready}),
        64'd0);
    chk("rst_sb", {sb_x, sb_m}, 64'd0);
    chk("rst_rsp", {rsp_x, rsp_m}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] x1;
    logic [31:0] m1;

    // Reset state
    do_reset();

    // Single request, L = 3
    lat        = 3;
    req0_x     = 32'h0123_4567;
    req0_m     = 32'hA5A5_A5A5;
    req0_valid = 1'b1;
    #1;
    chk("single_ready", 64'({req1_ready, req0_ready}), 64'b01);
    step();
    req0_valid = 1'b0;
    chk("single_start", 64'({sb_start, busy}), 64'b11);
    chk("single_sb", {sb_x, sb_m}, {32'h0123_4567, 32'hA5A5_A5A5});
    step();
    chk("single_start_pulse", 64'(sb_start), 64'd0);
    step();
    step();
    chk("single_rsp_early", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    step();
    chk("single_rsp_t5", 64'({rsp1_valid, rsp0_valid}), 64'b01);
    chk("single_rsp_data", {rsp_x, rsp_m}, {fx(32'h0123_4567), fm(32'hA5A5_A5A5)});
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    chk("single_idle", 64'({busy, rsp0_valid, rsp1_valid}), 64'd0);
    chk("single_cleared", {sb_x, rsp_x}, 64'd0);

    // Contention: both valid continuously after reset, grants alternate 0,1,0,1
    do_reset();
    lat        = 2;
    req0_x     = 32'h1111_0000;
    req0_m     = 32'h0000_1111;
    req1_x     = 32'h2222_0000;
    req1_m     = 32'h0000_2222;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        step();
        n++;
      end
      chk("contention_grant", 64'({req1_ready, req0_ready}), (k % 2 == 1) ? 64'b10 : 64'b01);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain(30);

    // Backpressure on port 1
    lat        = 1;
    x1         = 32'hDEAD_BEEF;
    m1         = 32'h1357_9BDF;
    req1_x     = x1;
    req1_m     = m1;
    req1_valid = 1'b1;
    #1;
    step();
    req1_valid = 1'b0;
    wait_rsp(1'b1, 10);
    req0_x     = 32'hCAFE_F00D;
    req0_m     = 32'h2468_ACE0;
    req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rsp_data", {rsp_x, rsp_m}, {fx(x1), fm(m1)});
      chk("bp_hold", 64'({rsp1_valid, req0_ready, sb_start}), 64'b100);
      step();
    end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    chk("bp_next_accept", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    drain(20);

    // Stale finish held across ISSUE
    lat        = 0;
    stale_hold = 1'b1;
    req0_x     = 32'h89AB_CDEF;
    req0_m     = 32'h5A5A_0FF0;
    req0_valid = 1'b1;
    #1;
    step();
    req0_valid = 1'b0;
    chk("stale_issue", 64'(sb_start), 64'd1);
    step();
    chk("stale_not_in_issue", 64'(rsp0_valid), 64'd0);
    step();
    chk("stale_done_in_wait", 64'(rsp0_valid), 64'd1);
    chk("stale_data", {rsp_x, rsp_m}, {fx(32'h89AB_CDEF), fm(32'h5A5A_0FF0)});
    stale_hold = 1'b0;
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;

    // Timeout: S-box never finishes
    lat        = 0;
    req1_x     = 32'h0F0F_0F0F;
    req1_m     = 32'hF0F0_F0F0;
    req1_valid = 1'b1;
    #1;
    step();
    req0_valid = 1'b1;
    for (int i = 0; i < 17; i++) step();
    chk("timeout_not_yet", 64'(err), 64'd0);
    step();
    chk("timeout_err", 64'({err, busy}), 64'b11);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("timeout_quiet", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, sb_start}),
          64'd0);
      chk("timeout_sticky", 64'(err), 64'd1);
      step();
    end
    do_reset();
    chk("timeout_recover", 64'({err, busy}), 64'd0);

    // Reset during WAIT; port 0 served last beforehand, port 0 still wins after reset
    lat        = 6;
    req0_x     = 32'h7777_8888;
    req0_m     = 32'h9999_AAAA;
    req0_valid = 1'b1;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    step();
    chk("midwait_busy", 64'(busy), 64'd1);
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("midwait_first_tie", 64'({req1_ready, req0_ready}), 64'b01);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
